alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_seq_pkg.sv | 40 ++++
 rtl/alu_cmd_fifo.sv | 70 +++++++
 rtl/alu_cmd_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU command sequencer: opcode encodings,
// FSM state type, command record layout and small decode helpers.
package alu_seq_pkg;

   // Opcode encodings as carried on cmd_op / alu_op_sel / rsp_op
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   // Result reported for divide-by-zero and for a timed-out MUL/DIV
   localparam logic [15:0] ERR_RESULT = 16'hFFFF;

   // Width of one queued command {a, b, op}
   localparam int CMD_W = 18;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ISSUE = 2'b01,
      ST_WAIT  = 2'b10,
      ST_RESP  = 2'b11
   } seq_state_e;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] op;
   } cmd_t;

   // MUL and DIV finish on alu_done; ADD and SUB finish in one cycle
   function automatic logic is_multicycle(input logic [1:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   // A DIV whose divisor is zero is answered without touching the ALU
   function automatic logic is_div_by_zero(input cmd_t cmd);
      return (cmd.op == OP_DIV) && (cmd.b == 8'd0);
   endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with parameterised depth (power of two) and width.
// The head entry is presented combinationally on rd_data whenever not empty.
module alu_cmd_fifo
   import alu_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = CMD_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] PTR_ONE = AW'(1'b1);
   localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1'b1);
   localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full    = (count_r == CNT_MAX);
   assign empty   = (count_r == '0);
   assign rd_data = mem_r[rd_ptr_r];

   // Qualify requests: a push is dropped when full, a pop when empty.
   // Push and pop in the same cycle are both honoured when not full.
   always_comb begin
      push_ok_s = push && !full;
      pop_ok_s  = pop && !empty;
   end

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Storage array; contents need no reset because occupancy gates reads
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU command sequencer: queues {a, b, op} commands, issues them one at a
// time to an external ALU, waits for the result (with timeout for MUL/DIV)
// and holds a response until the consumer takes it.
module alu_cmd_sequencer
   import alu_seq_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int DONE_TIMEOUT = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   input  logic [1:0]  cmd_op,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [1:0]  alu_op_sel,
   output logic        alu_load,
   input  logic [15:0] alu_result,
   input  logic        alu_done,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [1:0]  rsp_op,
   output logic        rsp_err,
   output logic        busy
);

   // Timeout counter counts completed WAIT cycles; the last allowed one is
   // DONE_TIMEOUT-1, so a missing alu_done leaves after exactly
   // DONE_TIMEOUT cycles in WAIT.
   localparam int TW = $clog2(DONE_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(DONE_TIMEOUT - 1);
   localparam logic [TW-1:0] TO_ONE  = TW'(1'b1);

   seq_state_e    state_r;
   logic [TW-1:0] to_cnt_r;
   logic [7:0]    alu_a_r;
   logic [7:0]    alu_b_r;
   logic [1:0]    alu_op_r;
   logic          alu_load_r;
   logic          rsp_valid_r;
   logic [15:0]   rsp_result_r;
   logic [1:0]    rsp_op_r;
   logic          rsp_err_r;

   logic          fifo_full_s;
   logic          fifo_empty_s;
   logic          fifo_push_s;
   logic          fifo_pop_s;
   logic [CMD_W-1:0] fifo_wr_data_s;
   logic [CMD_W-1:0] fifo_rd_data_s;
   cmd_t          head_s;

   alu_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_W)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (fifo_push_s),
      .wr_data (fifo_wr_data_s),
      .pop     (fifo_pop_s),
      .rd_data (fifo_rd_data_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s)
   );

   // Handshake and FIFO control; cmd_ready depends only on FIFO state
   always_comb begin
      fifo_wr_data_s = {cmd_a, cmd_b, cmd_op};
      head_s         = cmd_t'(fifo_rd_data_s);
      fifo_push_s    = cmd_valid && !fifo_full_s;
      if ((state_r == ST_IDLE) && !fifo_empty_s) begin
         fifo_pop_s = 1'b1;
      end else begin
         fifo_pop_s = 1'b0;
      end
   end

   // Sequencer FSM with registered ALU drive and response outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         to_cnt_r     <= '0;
         alu_a_r      <= 8'd0;
         alu_b_r      <= 8'd0;
         alu_op_r     <= 2'b00;
         alu_load_r   <= 1'b0;
         rsp_valid_r  <= 1'b0;
         rsp_result_r <= 16'd0;
         rsp_op_r     <= 2'b00;
         rsp_err_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (!fifo_empty_s) begin
                  alu_a_r  <= head_s.a;
                  alu_b_r  <= head_s.b;
                  alu_op_r <= head_s.op;
                  if (is_div_by_zero(head_s)) begin
                     // Answer immediately; the ALU never sees this command
                     rsp_result_r <= ERR_RESULT;
                     rsp_op_r     <= head_s.op;
                     rsp_err_r    <= 1'b1;
                     rsp_valid_r  <= 1'b1;
                     state_r      <= ST_RESP;
                  end else begin
                     alu_load_r <= 1'b1;
                     state_r    <= ST_ISSUE;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end

            ST_ISSUE: begin
               alu_load_r <= 1'b0;
               to_cnt_r   <= '0;
               state_r    <= ST_WAIT;
            end

            ST_WAIT: begin
               if (!is_multicycle(alu_op_r)) begin
                  // Single-cycle ops: result is valid in the first WAIT cycle
                  rsp_result_r <= alu_result;
                  rsp_op_r     <= alu_op_r;
                  rsp_err_r    <= 1'b0;
                  rsp_valid_r  <= 1'b1;
                  state_r      <= ST_RESP;
               end else if (alu_done) begin
                  rsp_result_r <= alu_result;
                  rsp_op_r     <= alu_op_r;
                  rsp_err_r    <= 1'b0;
                  rsp_valid_r  <= 1'b1;
                  state_r      <= ST_RESP;
               end else if (to_cnt_r == TO_LAST) begin
                  rsp_result_r <= ERR_RESULT;
                  rsp_op_r     <= alu_op_r;
                  rsp_err_r    <= 1'b1;
                  rsp_valid_r  <= 1'b1;
                  state_r      <= ST_RESP;
               end else begin
                  to_cnt_r <= to_cnt_r + TO_ONE;
                  state_r  <= ST_WAIT;
               end
            end

            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_r <= 1'b0;
                  state_r     <= ST_IDLE;
               end else begin
                  state_r <= ST_RESP;
               end
            end

            default: begin
               alu_load_r  <= 1'b0;
               rsp_valid_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   // Output mapping; busy covers both the in-flight and the queued commands
   always_comb begin
      cmd_ready  = !fifo_full_s;
      alu_a      = alu_a_r;
      alu_b      = alu_b_r;
      alu_op_sel = alu_op_r;
      alu_load   = alu_load_r;
      rsp_valid  = rsp_valid_r;
      rsp_result = rsp_result_r;
      rsp_op     = rsp_op_r;
      rsp_err    = rsp_err_r;
      if ((state_r != ST_IDLE) || !fifo_empty_s) begin
         busy = 1'b1;
      end else begin
         busy = 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a response scoreboard.
module tb_alu_cmd_sequencer;
   import alu_seq_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_a;
   logic [7:0]  cmd_b;
   logic [1:0]  cmd_op;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [1:0]  alu_op_sel;
   logic        alu_load;
   logic [15:0] alu_result;
   logic        alu_done;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_result;
   logic [1:0]  rsp_op;
   logic        rsp_err;
   logic        busy;

   typedef struct {
      logic [15:0] res;
      logic [1:0]  op;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   load_cyc = 0;
   int   rsp_cyc = 0;
   int   load_cnt = 0;
   bit   rsp_valid_q = 1'b0;
   int   done_delay = 5;
   int   cd = 0;
   bit   cd_active = 1'b0;

   alu_cmd_sequencer #(.FIFO_DEPTH(4), .DONE_TIMEOUT(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .cmd_op     (cmd_op),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op_sel (alu_op_sel),
      .alu_load   (alu_load),
      .alu_result (alu_result),
      .alu_done   (alu_done),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_op     (rsp_op),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // External ALU: MUL/DIV results are only meaningful while alu_done is high
   always_comb begin
      logic [15:0] v;
      case (alu_op_sel)
         2'b00:   v = {8'h00, alu_a} + {8'h00, alu_b};
         2'b01:   v = {8'h00, alu_a} - {8'h00, alu_b};
         2'b10:   v = {8'h00, alu_a} * {8'h00, alu_b};
         default: v = (alu_b != 8'd0) ? {8'h00, alu_a / alu_b} : 16'h0000;
      endcase
      if (alu_op_sel[1] && !alu_done) alu_result = 16'hDEAD;
      else alu_result = v;
   end

   // alu_done pulses done_delay cycles after the alu_load cycle (0 = never)
   always @(negedge clk) begin
      if (reset) begin
         cd_active = 1'b0;
         alu_done  = 1'b0;
      end else begin
         alu_done = 1'b0;
         if (cd_active) begin
            cd = cd - 1;
            if (cd == 0) begin
               alu_done  = 1'b1;
               cd_active = 1'b0;
            end
         end
         if (alu_load && done_delay > 0) begin
            cd_active = 1'b1;
            cd        = done_delay;
         end
      end
   end

   // Timing recorder for issue strobes and response starts
   always @(negedge clk) begin
      if (alu_load) begin
         load_cyc = cyc;
         load_cnt++;
      end
      if (rsp_valid && !rsp_valid_q) rsp_cyc = cyc;
      rsp_valid_q = rsp_valid;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every consumed response must match the head of the scoreboard
   always @(negedge clk) begin
      if (!reset && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got result %0h op %0h with no response expected",
                     rsp_result, rsp_op);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("rsp_result", rsp_result, e.res);
            check("rsp_op", rsp_op, e.op);
            check("rsp_err", rsp_err, e.err);
         end
      end
   end

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       output bit acc);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      acc       = cmd_ready;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while ((sb.size() != 0 || busy) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_pending"}, sb.size(), 0);
      check({name, "_busy"}, busy, 1'b0);
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int accepted;
      int lc0;
      logic [7:0]  bp_a [7] = '{8'd1, 8'd3, 8'd5, 8'd7, 8'd9, 8'd11, 8'd13};
      logic [7:0]  bp_b [7] = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12, 8'd14};
      logic [15:0] bp_r [7] = '{16'd3, 16'd7, 16'd11, 16'd15, 16'd19, 16'd23, 16'd27};

      reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_a = 8'd0;
      cmd_b = 8'd0;
      cmd_op = 2'b00;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset_cmd_ready", cmd_ready, 1'b1);
      check("reset_rsp_valid", rsp_valid, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_alu_load", alu_load, 1'b0);
      check("reset_alu_a", alu_a, 8'd0);
      check("reset_rsp_result", rsp_result, 16'd0);
      check("reset_rsp_err", rsp_err, 1'b0);

      // ADD 200+100
      lc0 = load_cnt;
      sb.push_back('{16'd300, OP_ADD, 1'b0});
      send(8'd200, 8'd100, OP_ADD, acc);
      wait_drain("add", 50);
      check("add_load_pulses", load_cnt - lc0, 1);
      check("add_latency", rsp_cyc - load_cyc, 2);

      // MUL 12*13 with done 5 cycles after load
      done_delay = 5;
      sb.push_back('{16'd156, OP_MUL, 1'b0});
      send(8'd12, 8'd13, OP_MUL, acc);
      wait_drain("mul", 50);
      check("mul_latency", rsp_cyc - load_cyc, 6);

      // DIV by zero never reaches the ALU
      lc0 = load_cnt;
      sb.push_back('{16'hFFFF, OP_DIV, 1'b1});
      send(8'd50, 8'd0, OP_DIV, acc);
      wait_drain("div0", 50);
      check("div0_no_load", load_cnt - lc0, 0);

      // Back-pressure: 7 back-to-back commands, 4 queued + 1 in flight
      rsp_ready = 1'b0;
      accepted = 0;
      for (int i = 0; i < 7; i++) begin
         send(bp_a[i], bp_b[i], OP_ADD, acc);
         if (acc) begin
            accepted++;
            sb.push_back('{bp_r[i], OP_ADD, 1'b0});
         end
      end
      @(negedge clk);
      check("bp_accepted", accepted, 5);
      check("bp_cmd_ready_low", cmd_ready, 1'b0);
      check("bp_held_valid", rsp_valid, 1'b1);
      check("bp_held_result", rsp_result, 16'd3);
      rsp_ready = 1'b1;
      wait_drain("bp", 200);
      check("bp_cmd_ready_high", cmd_ready, 1'b1);

      // MUL timeout: no alu_done at all
      done_delay = 0;
      lc0 = load_cnt;
      sb.push_back('{16'hFFFF, OP_MUL, 1'b1});
      send(8'd3, 8'd4, OP_MUL, acc);
      wait_drain("timeout", 100);
      check("timeout_latency", rsp_cyc - load_cyc, 33);
      check("timeout_load_pulses", load_cnt - lc0, 1);

      // Reset while waiting with three commands queued
      send(8'd2, 8'd3, OP_MUL, acc);
      send(8'd1, 8'd1, OP_ADD, acc);
      send(8'd1, 8'd1, OP_ADD, acc);
      send(8'd1, 8'd1, OP_ADD, acc);
      repeat (3) @(negedge clk);
      check("pre_reset_busy", busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      check("rst_alu_load", alu_load, 1'b0);
      check("rst_alu_a", alu_a, 8'd0);
      check("rst_alu_b", alu_b, 8'd0);
      check("rst_alu_op", alu_op_sel, 2'b00);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_result", rsp_result, 16'd0);
      check("rst_rsp_op", rsp_op, 2'b00);
      check("rst_rsp_err", rsp_err, 1'b0);
      check("rst_busy", busy, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      repeat (40) @(negedge clk);
      check("rst_idle_after", busy, 1'b0);

      // Sequencer still works after reset
      sb.push_back('{16'd42, OP_ADD, 1'b0});
      send(8'd20, 8'd22, OP_ADD, acc);
      wait_drain("post_reset", 50);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
